// File: rtl/bf_loader.sv
// bf_loader: front end of the brainhack core. Takes Brainfuck source bytes over
// a valid/ready handshake, drops everything that is not an instruction, encodes
// the rest to 3-bit opcodes and writes them into program memory from address 0.
// Bracket balance, nesting depth and program size are checked on the way.
// An end-of-program byte writes a 000 end marker and releases the core.
module bf_loader #(
   parameter int         PRGMEM_ADDR_WIDTH = 8,
   parameter int         STACK_ADDR_WIDTH  = 4,
   parameter logic [7:0] EOT_BYTE          = 8'h00
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         i_valid,
   input  logic [7:0]                   i_byte,
   output logic                         o_ready,
   input  logic                         i_start,
   output logic                         o_prgmem_we,
   output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
   output logic [2:0]                   o_prgmem_data,
   output logic [PRGMEM_ADDR_WIDTH-1:0] o_length,
   output logic                         o_done,
   output logic [1:0]                   o_error,
   output logic                         o_cpu_run
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_TERM  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [2:0] OP_END   = 3'b000;
   localparam logic [2:0] OP_OPEN  = 3'b110;
   localparam logic [2:0] OP_CLOSE = 3'b111;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_PROG     = 2'b01;
   localparam logic [1:0] ERR_UNBAL    = 2'b10;
   localparam logic [1:0] ERR_NEST     = 2'b11;

   // The top slot is kept free so the end marker always has somewhere to go.
   localparam logic [PRGMEM_ADDR_WIDTH-1:0] LAST_SLOT = '1;
   localparam logic [PRGMEM_ADDR_WIDTH-1:0] ADDR_ONE  = PRGMEM_ADDR_WIDTH'(1);
   localparam logic [STACK_ADDR_WIDTH:0]    MAX_DEPTH = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};
   localparam logic [STACK_ADDR_WIDTH:0]    DEPTH_ONE = (STACK_ADDR_WIDTH+1)'(1);

   state_t                         state;
   logic [PRGMEM_ADDR_WIDTH-1:0]   count;
   logic [STACK_ADDR_WIDTH:0]      depth;
   logic                           is_op;
   logic [2:0]                     opcode;
   logic                           is_eot;
   logic                           accept;

   assign o_ready = (state == S_LOAD) && !i_reset;
   assign accept  = i_valid && o_ready;
   assign is_eot  = (i_byte == EOT_BYTE);

   // Map the six instruction characters onto their opcodes; anything else is filler.
   always_comb begin
      is_op  = 1'b1;
      opcode = OP_END;
      case (i_byte)
         8'h2B:   opcode = 3'b010;
         8'h2D:   opcode = 3'b011;
         8'h3E:   opcode = 3'b100;
         8'h3C:   opcode = 3'b101;
         8'h5B:   opcode = OP_OPEN;
         8'h5D:   opcode = OP_CLOSE;
         default: is_op = 1'b0;
      endcase
   end

   // Loader FSM: checks each accepted byte before writing it, then terminates or traps.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= S_LOAD;
         count         <= '0;
         depth         <= '0;
         o_prgmem_we   <= 1'b0;
         o_prgmem_addr <= '0;
         o_prgmem_data <= OP_END;
         o_length      <= '0;
         o_done        <= 1'b0;
         o_error       <= ERR_NONE;
         o_cpu_run     <= 1'b0;
      end else begin
         o_prgmem_we <= 1'b0;
         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (is_eot) begin
                     if (depth != '0) begin
                        state   <= S_ERROR;
                        o_error <= ERR_UNBAL;
                     end else begin
                        state         <= S_TERM;
                        o_length      <= count;
                        o_prgmem_we   <= 1'b1;
                        o_prgmem_addr <= count;
                        o_prgmem_data <= OP_END;
                     end
                  end else if (is_op) begin
                     if (count == LAST_SLOT) begin
                        state   <= S_ERROR;
                        o_error <= ERR_PROG;
                     end else if (opcode == OP_CLOSE && depth == '0) begin
                        state   <= S_ERROR;
                        o_error <= ERR_UNBAL;
                     end else if (opcode == OP_OPEN && depth == MAX_DEPTH) begin
                        state   <= S_ERROR;
                        o_error <= ERR_NEST;
                     end else begin
                        o_prgmem_we   <= 1'b1;
                        o_prgmem_addr <= count;
                        o_prgmem_data <= opcode;
                        count         <= count + ADDR_ONE;
                        if (opcode == OP_OPEN) begin
                           depth <= depth + DEPTH_ONE;
                        end else if (opcode == OP_CLOSE) begin
                           depth <= depth - DEPTH_ONE;
                        end
                     end
                  end
               end
            end
            S_TERM: begin
               state     <= S_DONE;
               o_done    <= 1'b1;
               o_cpu_run <= 1'b1;
            end
            S_DONE, S_ERROR: begin
               if (i_start) begin
                  state     <= S_LOAD;
                  count     <= '0;
                  depth     <= '0;
                  o_length  <= '0;
                  o_error   <= ERR_NONE;
                  o_done    <= 1'b0;
                  o_cpu_run <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf_loader.sv
// tb_bf_loader: drives directed Brainfuck streams into bf_loader and checks every
// cycle against a byte-level model of the loader, plus literal memory images.
module tb_bf_loader;

   localparam int AW     = 8;
   localparam int SW     = 4;
   localparam int SLOTS  = 1 << AW;
   localparam int NEST   = 1 << SW;

   localparam int M_LOADING     = 0;
   localparam int M_TERMINATING = 1;
   localparam int M_FINISHED    = 2;
   localparam int M_ERRORED     = 3;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_valid = 1'b0;
   logic [7:0]    i_byte  = 8'h00;
   logic          i_start = 1'b0;
   logic          o_ready;
   logic          o_prgmem_we;
   logic [AW-1:0] o_prgmem_addr;
   logic [2:0]    o_prgmem_data;
   logic [AW-1:0] o_length;
   logic          o_done;
   logic [1:0]    o_error;
   logic          o_cpu_run;

   int compared   = 0;
   int mismatched = 0;

   // Model of what the loader has been told so far, stepped once per clock.
   int m_mode   = M_LOADING;
   int m_count  = 0;
   int m_depth  = 0;
   int m_we     = 0;
   int m_addr   = 0;
   int m_data   = 0;
   int m_length = 0;
   int m_done   = 0;
   int m_run    = 0;
   int m_err    = 0;

   // Image of program memory as written by the DUT; 001 marks a slot never written.
   logic [2:0] dut_mem [SLOTS];
   int         writes = 0;

   bf_loader #(
      .PRGMEM_ADDR_WIDTH(AW),
      .STACK_ADDR_WIDTH (SW),
      .EOT_BYTE         (8'h00)
   ) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .i_byte       (i_byte),
      .o_ready      (o_ready),
      .i_start      (i_start),
      .o_prgmem_we  (o_prgmem_we),
      .o_prgmem_addr(o_prgmem_addr),
      .o_prgmem_data(o_prgmem_data),
      .o_length     (o_length),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_cpu_run    (o_cpu_run)
   );

   always #5 i_clock = ~i_clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int opOf(input logic [7:0] b);
      string ops;
      ops = "+-><[]";
      for (int k = 0; k < 6; k++) begin
         if (ops[k] == b) return k + 2;
      end
      return -1;
   endfunction

   task automatic modelError(input int code);
      m_err  = code;
      m_mode = M_ERRORED;
   endtask

   task automatic modelByte(input logic [7:0] b);
      int op;
      op = opOf(b);
      if (b == 8'h00) begin
         if (m_depth != 0) begin
            modelError(2);
         end else begin
            m_length = m_count;
            m_we     = 1;
            m_addr   = m_count;
            m_data   = 0;
            m_mode   = M_TERMINATING;
         end
      end else if (op >= 0) begin
         if (m_count == SLOTS - 1) begin
            modelError(1);
         end else if (op == 7 && m_depth == 0) begin
            modelError(2);
         end else if (op == 6 && m_depth == NEST) begin
            modelError(3);
         end else begin
            m_we    = 1;
            m_addr  = m_count;
            m_data  = op;
            m_count = m_count + 1;
            if (op == 6) m_depth = m_depth + 1;
            if (op == 7) m_depth = m_depth - 1;
         end
      end
   endtask

   task automatic modelStep();
      if (i_reset) begin
         m_mode = M_LOADING; m_count = 0; m_depth = 0; m_we = 0; m_addr = 0;
         m_data = 0; m_length = 0; m_done = 0; m_run = 0; m_err = 0;
      end else begin
         m_we = 0;
         if (m_mode == M_LOADING) begin
            if (i_valid) modelByte(i_byte);
         end else if (m_mode == M_TERMINATING) begin
            m_mode = M_FINISHED;
            m_done = 1;
            m_run  = 1;
         end else if (i_start) begin
            m_mode = M_LOADING; m_count = 0; m_depth = 0; m_length = 0;
            m_err = 0; m_done = 0; m_run = 0;
         end
      end
   endtask

   // Per-cycle compare: inputs change only after this point, so they are the ones the last edge saw.
   initial begin
      for (int a = 0; a < SLOTS; a++) dut_mem[a] = 3'b001;
      forever begin
         @(negedge i_clock);
         modelStep();
         checkOutput("ready", int'(o_ready), (m_mode == M_LOADING && !i_reset) ? 1 : 0);
         checkOutput("we", int'(o_prgmem_we), m_we);
         if (i_reset) begin
            checkOutput("rst_addr", int'(o_prgmem_addr), 0);
            checkOutput("rst_data", int'(o_prgmem_data), 0);
         end else if (m_we != 0) begin
            checkOutput("addr", int'(o_prgmem_addr), m_addr);
            checkOutput("data", int'(o_prgmem_data), m_data);
         end
         checkOutput("length", int'(o_length), m_length);
         checkOutput("done", int'(o_done), m_done);
         checkOutput("error", int'(o_error), m_err);
         checkOutput("cpu_run", int'(o_cpu_run), m_run);
         if (o_prgmem_we) begin
            dut_mem[o_prgmem_addr] = o_prgmem_data;
            writes++;
         end
      end
   end

   task automatic nextCycle();
      @(negedge i_clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      i_valid = 1'b1;
      i_byte  = b;
      nextCycle();
      i_valid = 1'b0;
      repeat (gap) nextCycle();
   endtask

   task automatic sendString(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i], gap);
   endtask

   task automatic sendRepeat(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) applyStimulus(b, 0);
   endtask

   task automatic pulseStart();
      i_start = 1'b1;
      nextCycle();
      i_start = 1'b0;
   endtask

   task automatic checkFinal(input string tag, input int nwrites, input int len,
                             input int done, input int err, input int run);
      checkOutput({tag, "_writes"}, nwrites, 0);
      checkOutput({tag, "_length"}, int'(o_length), len);
      checkOutput({tag, "_done"}, int'(o_done), done);
      checkOutput({tag, "_error"}, int'(o_error), err);
      checkOutput({tag, "_cpu_run"}, int'(o_cpu_run), run);
   endtask

   // Directed scenarios, each pinned by hand-computed memory images and output levels.
   initial begin
      int base;
      logic [2:0] img1 [8];
      img1 = '{3'b010, 3'b110, 3'b011, 3'b100, 3'b010, 3'b101, 3'b111, 3'b000};

      nextCycle();
      checkOutput("reset_ready", int'(o_ready), 0);
      checkOutput("reset_cpu_run", int'(o_cpu_run), 0);
      nextCycle();
      i_reset = 1'b0;
      nextCycle();
      checkOutput("idle_ready", int'(o_ready), 1);

      base = writes;
      sendString("+[->+<]", 0);
      applyStimulus(8'h00, 3);
      checkFinal("loop", writes - base - 8, 7, 1, 0, 1);
      for (int a = 0; a < 8; a++) checkOutput("loop_mem", int'(dut_mem[a]), int'(img1[a]));

      pulseStart();
      base = writes;
      sendString("a+ b.\n-", 1);
      applyStimulus(8'h00, 3);
      checkFinal("filter", writes - base - 3, 2, 1, 0, 1);
      checkOutput("filter_mem0", int'(dut_mem[0]), 3'b010);
      checkOutput("filter_mem1", int'(dut_mem[1]), 3'b011);
      checkOutput("filter_mem2", int'(dut_mem[2]), 3'b000);

      pulseStart();
      base = writes;
      applyStimulus(8'h5D, 3);
      checkFinal("close", writes - base, 0, 0, 2, 0);
      checkOutput("close_ready", int'(o_ready), 0);

      pulseStart();
      base = writes;
      sendString("[[", 0);
      applyStimulus(8'h00, 3);
      checkFinal("open2", writes - base - 2, 0, 0, 2, 0);

      pulseStart();
      base = writes;
      sendRepeat(8'h5B, NEST + 1);
      repeat (2) nextCycle();
      checkFinal("nest", writes - base - NEST, 0, 0, 3, 0);

      pulseStart();
      base = writes;
      sendRepeat(8'h2B, SLOTS);
      repeat (2) nextCycle();
      checkFinal("full", writes - base - (SLOTS - 1), 0, 0, 1, 0);
      checkOutput("full_mem254", int'(dut_mem[SLOTS-2]), 3'b010);
      checkOutput("full_mem255", int'(dut_mem[SLOTS-1]), 3'b001);

      pulseStart();
      base = writes;
      sendRepeat(8'h2B, SLOTS - 1);
      applyStimulus(8'h00, 3);
      checkFinal("max", writes - base - SLOTS, SLOTS - 1, 1, 0, 1);
      checkOutput("max_mem255", int'(dut_mem[SLOTS-1]), 3'b000);

      pulseStart();
      sendString("+>", 2);
      applyStimulus(8'h2D, 0);
      i_valid = 1'b1;
      i_byte  = 8'h3C;
      @(posedge i_clock);
      #2;
      i_reset = 1'b1;
      #1;
      checkOutput("async_ready", int'(o_ready), 0);
      checkOutput("async_we", int'(o_prgmem_we), 0);
      checkOutput("async_addr", int'(o_prgmem_addr), 0);
      checkOutput("async_length", int'(o_length), 0);
      @(negedge i_clock);
      #1;
      i_valid = 1'b0;
      nextCycle();
      i_reset = 1'b0;

      base = writes;
      sendString("-<", 1);
      i_valid = 1'b1;
      i_byte  = 8'h00;
      nextCycle();
      i_byte  = 8'h2B;
      repeat (3) nextCycle();
      checkFinal("stall", writes - base - 3, 2, 1, 0, 1);
      checkOutput("stall_mem0", int'(dut_mem[0]), 3'b011);
      checkOutput("stall_mem1", int'(dut_mem[1]), 3'b101);
      checkOutput("stall_mem2", int'(dut_mem[2]), 3'b000);

      base = writes;
      i_start = 1'b1;
      nextCycle();
      i_start = 1'b0;
      i_valid = 1'b0;
      nextCycle();
      checkFinal("rearm", writes - base, 0, 0, 0, 0);
      checkOutput("rearm_ready", int'(o_ready), 1);

      base = writes;
      applyStimulus(8'h2B, 0);
      applyStimulus(8'h00, 3);
      checkFinal("restart", writes - base - 2, 1, 1, 0, 1);
      checkOutput("restart_mem0", int'(dut_mem[0]), 3'b010);
      checkOutput("restart_mem1", int'(dut_mem[1]), 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
